// File: rtl/memory_arbiter.sv
// memory_arbiter
// Shares the single memory_controller port between instruction fetch (read-only)
// and data load/store. One access is outstanding at a time. Data wins ties, but a
// streak limit on consecutive data grants keeps a waiting fetch from starving.
// Every output is a flop, so nothing reaches the memory port or the requesters
// combinationally from an input.
module memory_arbiter #(
   parameter int TIMEOUT      = 16,
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   output logic        i_abort,
   input  logic        d_req,
   input  logic        d_write,
   input  logic        d_size,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_abort,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic        m_write,
   output logic        m_size,
   output logic [1:0]  m_prot,
   output logic [1:0]  m_trans,
   input  logic [31:0] m_rdata,
   input  logic        m_data_valid,
   input  logic        m_abort
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);
   localparam logic [SW-1:0] STREAK_MAX   = SW'(MAX_D_STREAK);
   localparam logic [1:0]    TRANS_IDLE   = 2'b00;
   localparam logic [1:0]    TRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmo_q;       // WAIT cycles spent without m_data_valid
   logic [SW-1:0] streak_q;    // consecutive data grants while fetch was waiting
   logic          is_data_q;   // current access belongs to the data requester
   logic          pick_data;   // data would win an arbitration this cycle
   logic          finish;      // WAIT ends at this edge
   logic          fin_abort;   // abort status reported with the ack

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of the order the always blocks are evaluated in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state: one pass IDLE -> ISSUE -> WAIT -> DONE per access.
   // NOTE: state_d gets a default before the case so no path leaves it unassigned
   // (an unassigned path in always_comb would infer a latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_req || d_req) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (m_data_valid || tmo_q == TMO_LAST) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Arbitration and completion decisions feeding the output registers.
   always_comb begin
      pick_data = d_req && !(i_req && streak_q == STREAK_MAX);
      finish    = (state_q == S_WAIT) && (state_d == S_DONE);
      fin_abort = m_data_valid ? m_abort : 1'b1;   // no data_valid means timeout
   end

   // Registered outputs, latched request fields and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_addr    <= '0;
         m_wdata   <= '0;
         m_write   <= 1'b0;
         m_size    <= 1'b0;
         m_prot    <= 2'b00;
         m_trans   <= TRANS_IDLE;
         i_rdata   <= '0;
         i_ack     <= 1'b0;
         i_abort   <= 1'b0;
         d_rdata   <= '0;
         d_ack     <= 1'b0;
         d_abort   <= 1'b0;
         is_data_q <= 1'b0;
         tmo_q     <= '0;
         streak_q  <= '0;
      end else begin
         // NONSEQ is visible exactly during the ISSUE cycle.
         m_trans <= (state_d == S_ISSUE) ? TRANS_NONSEQ : TRANS_IDLE;
         i_ack   <= 1'b0;
         d_ack   <= 1'b0;
         i_abort <= 1'b0;
         d_abort <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req || d_req) begin
                  is_data_q <= pick_data;
                  m_addr    <= pick_data ? d_addr : i_addr;
                  m_wdata   <= pick_data ? d_wdata : '0;
                  m_write   <= pick_data && d_write;
                  m_size    <= pick_data && d_size;
                  m_prot    <= {1'b0, pick_data};
                  // A data grant only extends the streak when fetch was kept waiting.
                  streak_q  <= (pick_data && i_req) ? streak_q + SW'(1) : '0;
               end
            end
            S_ISSUE: tmo_q <= '0;
            S_WAIT: begin
               if (finish) begin
                  m_write <= 1'b0;
                  i_ack   <= !is_data_q;
                  d_ack   <= is_data_q;
                  i_abort <= !is_data_q && fin_abort;
                  d_abort <= is_data_q && fin_abort;
                  // Read data is taken only from a real completion of a read.
                  if (m_data_valid && !m_write) begin
                     if (is_data_q) d_rdata <= m_rdata;
                     else           i_rdata <= m_rdata;
                  end
               end else begin
                  tmo_q <= tmo_q + TW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
